tluh_host_burst_adapter: RTL and testbench

Multi-outstanding, burst-capable TL-UH host adapter: converts a host-side request/write-data/response stream into TL-UH channel A/D traffic with multi-beat Put, Arithmetic and Logical requests and multi-beat AccessAckData responses. Up to MAX_REQS transactions are in flight on distinct sources. Out-of-order D-channel responses are collected in a per-source reorder buffer and returned to the host strictly in issue order. It sits between a core/DMA host and the TL-UH crossbar.

---
 rtl/tluh_pkg.sv | 49 ++++
 rtl/tluh_host_burst_adapter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_tluh_host_burst_adapter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tluh_pkg.sv
// TL-UH channel types and opcode constants shared by the host burst adapter
// and its bench.
//   tluh_h2d_t : host-to-device bundle (channel A fields plus d_ready)
//   tluh_d2h_t : device-to-host bundle (channel D fields plus a_ready)
package tluh_pkg;

  localparam int TL_AW  = 32;          // address width
  localparam int TL_DW  = 32;          // data width
  localparam int TL_DBW = TL_DW / 8;   // byte lanes per beat
  localparam int TL_AIW = 8;           // source id width
  localparam int TL_SZW = 4;           // log2(bytes) size field width

  // Channel A opcodes
  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  // Channel D opcodes
  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK = 3'd2;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tluh_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tluh_d2h_t;

endpackage

// File: rtl/tluh_host_burst_adapter.sv
// Multi-outstanding, burst-capable TL-UH host adapter.
// Turns a host request / write-data / response stream into TL-UH A/D traffic.
// Each accepted request takes the slot at alloc_ptr; the slot index is the
// A-channel source. D beats may come back out of order across sources and are
// parked in the slot's beat storage. Responses go back to the host strictly
// in issue order, starting from ret_ptr.
//
// Handshakes: every channel (req, w, rsp, A, D) transfers a beat on a rising
// edge where valid && ready. A source never withdraws valid or changes its
// payload while waiting for ready. The exception is data-op A beats, which
// are a combinational pass-through of wvalid_i/wdata_i/wbe_i.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_*                     request: op, param, byte address, log2(beats)
//   wvalid_i/wready_o/wdata_i/wbe_i   write-data beats for Put/Arith/Logical
//   rsp_*                     in-order response beats with error and last flags
//   proto_err_o               sticky protocol error (bad D beat or reserved op)
//   a_busy_o                  A FSM state (1 = SEND)
//   tl_h_c_a / tl_h_c_d       TL-UH host-to-device / device-to-host bundles
module tluh_host_burst_adapter
  import tluh_pkg::*;
#(
  parameter int  MAX_REQS  = 4,
  parameter int  MAX_BEATS = 4,
  localparam int LW        = $clog2(MAX_BEATS) + 1,
  localparam int LENW      = (LW > 1) ? LW - 1 : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [2:0]        req_param_i,
  input  logic [TL_AW-1:0]  req_addr_i,
  input  logic [LENW-1:0]   req_len_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [TL_DW-1:0]  wdata_i,
  input  logic [TL_DBW-1:0] wbe_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [TL_DW-1:0]  rsp_data_o,
  output logic              rsp_err_o,
  output logic              rsp_last_o,
  output logic              proto_err_o,
  output logic              a_busy_o,
  output tluh_h2d_t         tl_h_c_a,
  input  tluh_d2h_t         tl_h_c_d
);

  localparam int SW      = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
  localparam int BW      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int OCW     = $clog2(MAX_REQS + 1);
  localparam int LOG_DBW = $clog2(TL_DBW);
  localparam logic [SW-1:0] LAST_SLOT = SW'(MAX_REQS - 1);

  // Host-side op encoding
  localparam logic [2:0] OP_GET      = 3'd0;
  localparam logic [2:0] OP_PUT_FULL = 3'd1;
  localparam logic [2:0] OP_PUT_PART = 3'd2;
  localparam logic [2:0] OP_ARITH    = 3'd3;
  localparam logic [2:0] OP_LOGIC    = 3'd4;
  localparam logic [2:0] OP_INTENT   = 3'd5;

  typedef enum logic {A_IDLE = 1'b0, A_SEND = 1'b1} a_state_e;
  a_state_e a_state, a_state_next;

  function automatic logic [2:0] tl_opcode(input logic [2:0] op);
    case (op)
      OP_GET:      tl_opcode = A_GET;
      OP_PUT_FULL: tl_opcode = A_PUT_FULL;
      OP_PUT_PART: tl_opcode = A_PUT_PARTIAL;
      OP_ARITH:    tl_opcode = A_ARITH;
      OP_LOGIC:    tl_opcode = A_LOGICAL;
      default:     tl_opcode = A_INTENT;
    endcase
  endfunction

  function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] p);
    next_slot = (p == LAST_SLOT) ? '0 : p + SW'(1);
  endfunction

  // ---------------------------------------------------------------- decode
  logic              req_rsvd;
  logic [2:0]        req_op_eff;
  logic [2:0]        req_param_eff;
  logic              req_is_data;
  logic              req_has_rdata;
  logic              req_full_mask;
  logic [LW-1:0]     req_beats;
  logic [TL_SZW-1:0] req_size;
  logic [TL_AW-1:0]  req_addr_al;
  logic              req_fire;

  always_comb begin
    req_rsvd      = (req_op_i > OP_INTENT);
    // Reserved ops degrade to a harmless Intent with param 0.
    req_op_eff    = req_rsvd ? OP_INTENT : req_op_i;
    req_is_data   = (req_op_eff >= OP_PUT_FULL) && (req_op_eff <= OP_LOGIC);
    req_has_rdata = (req_op_eff == OP_GET) || (req_op_eff == OP_ARITH) ||
                    (req_op_eff == OP_LOGIC);
    req_full_mask = (req_op_eff == OP_GET) || (req_op_eff == OP_PUT_FULL) ||
                    (req_op_eff == OP_INTENT);
    req_param_eff = (!req_rsvd && (req_op_eff >= OP_ARITH)) ? req_param_i : 3'd0;
    req_beats     = LW'(1) << req_len_i;
    req_size      = TL_SZW'(LOG_DBW) + TL_SZW'(req_len_i);
    req_addr_al   = req_addr_i & ({TL_AW{1'b1}} << req_size);
  end

  // ------------------------------------------------------ current A message
  logic [2:0]        cur_opcode;
  logic [2:0]        cur_param;
  logic [TL_SZW-1:0] cur_size;
  logic [TL_AW-1:0]  cur_addr;
  logic [SW-1:0]     cur_src;
  logic [LW-1:0]     cur_beats;
  logic [LW-1:0]     a_cnt;
  logic              cur_is_data;
  logic              cur_full_mask;

  // ------------------------------------------------------------ slot table
  logic [MAX_REQS-1:0] slot_valid;
  logic [MAX_REQS-1:0] slot_has_rdata;
  logic [MAX_REQS-1:0] slot_err;
  logic [LW-1:0]       slot_exp [MAX_REQS];
  logic [LW-1:0]       slot_rx  [MAX_REQS];
  logic [LW-1:0]       slot_rd  [MAX_REQS];
  logic [TL_DW-1:0]    slot_mem [MAX_REQS][MAX_BEATS];
  logic [SW-1:0]       alloc_ptr;
  logic [SW-1:0]       ret_ptr;
  logic [OCW-1:0]      occupancy;

  // ----------------------------------------------------------- A channel FSM
  logic a_valid;
  logic a_last;
  logic a_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) a_state <= A_IDLE;
    else       a_state <= a_state_next;
  end

  always_comb begin
    a_state_next = a_state;
    a_valid      = 1'b0;
    a_last       = 1'b0;
    wready_o     = 1'b0;
    req_ready_o  = 1'b0;
    case (a_state)
      A_IDLE: begin
        // Pre-retire occupancy: a slot freed this cycle is reusable next cycle.
        req_ready_o = (occupancy < OCW'(MAX_REQS));
        if (req_valid_i && req_ready_o) a_state_next = A_SEND;
      end
      A_SEND: begin
        a_valid  = cur_is_data ? wvalid_i : 1'b1;
        wready_o = cur_is_data && tl_h_c_d.a_ready;
        a_last   = !cur_is_data || (a_cnt == cur_beats - LW'(1));
        if (a_valid && tl_h_c_d.a_ready && a_last) a_state_next = A_IDLE;
      end
      default: a_state_next = A_IDLE;
    endcase
  end

  assign a_fire   = a_valid && tl_h_c_d.a_ready;
  assign req_fire = req_valid_i && req_ready_o;
  assign a_busy_o = (a_state == A_SEND);

  always_comb begin
    tl_h_c_a           = '0;
    tl_h_c_a.a_valid   = a_valid;
    tl_h_c_a.a_opcode  = cur_opcode;
    tl_h_c_a.a_param   = cur_param;
    tl_h_c_a.a_size    = cur_size;
    tl_h_c_a.a_source  = TL_AIW'(cur_src);
    tl_h_c_a.a_address = cur_addr;
    tl_h_c_a.a_mask    = cur_full_mask ? {TL_DBW{1'b1}} : wbe_i;
    tl_h_c_a.a_data    = cur_is_data ? wdata_i : '0;
    // Storage for every response beat is reserved at allocation.
    tl_h_c_a.d_ready   = 1'b1;
  end

  // ------------------------------------------------------------- D channel
  logic [SW-1:0] d_idx;
  logic          d_in_range;
  logic          d_accept;
  logic          d_bad;
  logic          unused_d;

  assign d_idx      = tl_h_c_d.d_source[SW-1:0];
  assign d_in_range = ({{(32-TL_AIW){1'b0}}, tl_h_c_d.d_source} < 32'(MAX_REQS));
  assign d_accept   = tl_h_c_d.d_valid && d_in_range && slot_valid[d_idx] &&
                      (slot_rx[d_idx] < slot_exp[d_idx]);
  assign d_bad      = tl_h_c_d.d_valid && !d_accept;
  // Beat count comes from the request, not the D opcode/size fields.
  assign unused_d   = ^{tl_h_c_d.d_opcode, tl_h_c_d.d_param, tl_h_c_d.d_size};

  // -------------------------------------------------------------- response
  logic [LW-1:0] head_rd;
  logic          rsp_fire;
  logic          retire;

  always_comb begin
    head_rd     = slot_rd[ret_ptr];
    rsp_valid_o = slot_valid[ret_ptr] && (head_rd < slot_rx[ret_ptr]);
    rsp_last_o  = rsp_valid_o && (head_rd == slot_exp[ret_ptr] - LW'(1));
    rsp_err_o   = slot_valid[ret_ptr] && slot_err[ret_ptr];
    rsp_data_o  = rsp_valid_o ? slot_mem[ret_ptr][head_rd[BW-1:0]] : '0;
  end

  assign rsp_fire = rsp_valid_o && rsp_ready_i;
  assign retire   = rsp_fire && rsp_last_o;

  // ------------------------------------------------------------ state update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_opcode     <= '0;
      cur_param      <= '0;
      cur_size       <= '0;
      cur_addr       <= '0;
      cur_src        <= '0;
      cur_beats      <= '0;
      cur_is_data    <= 1'b0;
      cur_full_mask  <= 1'b0;
      a_cnt          <= '0;
      slot_valid     <= '0;
      slot_has_rdata <= '0;
      slot_err       <= '0;
      alloc_ptr      <= '0;
      ret_ptr        <= '0;
      occupancy      <= '0;
      proto_err_o    <= 1'b0;
    end else begin
      if (a_fire) a_cnt <= a_cnt + LW'(1);

      if (d_accept) begin
        slot_rx[d_idx]  <= slot_rx[d_idx] + LW'(1);
        slot_err[d_idx] <= slot_err[d_idx] | tl_h_c_d.d_error;
      end

      if (d_bad || (req_fire && req_rsvd)) proto_err_o <= 1'b1;

      if (rsp_fire) begin
        slot_rd[ret_ptr] <= head_rd + LW'(1);
        if (rsp_last_o) begin
          slot_valid[ret_ptr] <= 1'b0;
          ret_ptr             <= next_slot(ret_ptr);
        end
      end

      // alloc_ptr and ret_ptr only coincide when the table is empty or full,
      // so allocation and retirement never touch the same slot in one cycle.
      if (req_fire) begin
        cur_opcode                <= tl_opcode(req_op_eff);
        cur_param                 <= req_param_eff;
        cur_size                  <= req_size;
        cur_addr                  <= req_addr_al;
        cur_src                   <= alloc_ptr;
        cur_beats                 <= req_beats;
        cur_is_data               <= req_is_data;
        cur_full_mask             <= req_full_mask;
        a_cnt                     <= '0;
        slot_valid[alloc_ptr]     <= 1'b1;
        slot_has_rdata[alloc_ptr] <= req_has_rdata;
        slot_err[alloc_ptr]       <= 1'b0;
        slot_exp[alloc_ptr]       <= req_has_rdata ? req_beats : LW'(1);
        slot_rx[alloc_ptr]        <= '0;
        slot_rd[alloc_ptr]        <= '0;
        alloc_ptr                 <= next_slot(alloc_ptr);
      end

      case ({req_fire, retire})
        2'b10:   occupancy <= occupancy + OCW'(1);
        2'b01:   occupancy <= occupancy - OCW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Beat storage needs no reset: it is only read behind slot_valid/rx_cnt.
  always_ff @(posedge clk_i) begin
    if (!rst_i && d_accept)
      slot_mem[d_idx][slot_rx[d_idx][BW-1:0]] <=
        slot_has_rdata[d_idx] ? tl_h_c_d.d_data : '0;
  end

endmodule

// File: tb/tb_tluh_host_burst_adapter.sv
// Directed bench for tluh_host_burst_adapter: a linear sequence of steps in
// one initial block, with the bench acting as host and as TL-UH device.
module tb_tluh_host_burst_adapter;
  import tluh_pkg::*;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [2:0]        req_param;
  logic [TL_AW-1:0]  req_addr;
  logic [1:0]        req_len;
  logic              wvalid;
  logic              wready;
  logic [TL_DW-1:0]  wdata;
  logic [TL_DBW-1:0] wbe;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [TL_DW-1:0]  rsp_data;
  logic              rsp_err;
  logic              rsp_last;
  logic              proto_err;
  logic              a_busy;
  tluh_h2d_t         a_out;
  tluh_d2h_t         d_in;

  int errors = 0;
  int checks = 0;

  tluh_host_burst_adapter #(.MAX_REQS(4), .MAX_BEATS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_param_i (req_param),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .wvalid_i    (wvalid),
    .wready_o    (wready),
    .wdata_i     (wdata),
    .wbe_i       (wbe),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .rsp_last_o  (rsp_last),
    .proto_err_o (proto_err),
    .a_busy_o    (a_busy),
    .tl_h_c_a    (a_out),
    .tl_h_c_d    (d_in)
  );

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req_drive(input logic [2:0] op, input logic [2:0] param,
                           input logic [31:0] addr, input logic [1:0] len);
    req_valid = 1'b1;
    req_op    = op;
    req_param = param;
    req_addr  = addr;
    req_len   = len;
  endtask

  task automatic d_beat(input logic [7:0] src, input logic [2:0] op,
                        input logic [31:0] data, input logic err);
    d_in.d_valid  = 1'b1;
    d_in.d_source = src;
    d_in.d_opcode = op;
    d_in.d_data   = data;
    d_in.d_error  = err;
  endtask

  task automatic d_idle();
    d_in.d_valid = 1'b0;
    d_in.d_error = 1'b0;
    d_in.d_data  = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- sequence
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_param = '0; req_addr = '0;
    req_len = '0; wvalid = 1'b0; wdata = '0; wbe = '0; rsp_ready = 1'b0;
    d_in = '0; d_in.a_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_a_valid", a_out.a_valid, 0);
    chk("rst_d_ready", a_out.d_ready, 1);
    chk("rst_busy", a_busy, 0);

    // Get len=2 at 0x1003, source 0
    req_drive(3'd0, 3'd0, 32'h1003, 2'd2);
    settle();
    chk("get_req_ready", req_ready, 1);
    tick(); req_valid = 1'b0; settle();
    chk("get_a_valid", a_out.a_valid, 1);
    chk("get_a_opcode", a_out.a_opcode, A_GET);
    chk("get_a_size", a_out.a_size, 4);
    chk("get_a_address", a_out.a_address, 32'h1000);
    chk("get_a_mask", a_out.a_mask, 4'hF);
    chk("get_a_source", a_out.a_source, 0);
    chk("get_a_data", a_out.a_data, 0);
    chk("get_wready", wready, 0);
    chk("get_busy_ready", req_ready, 0);
    tick(); settle();
    chk("get_a_done", a_out.a_valid, 0);
    chk("get_ready_again", req_ready, 1);
    d_beat(8'd0, D_ACK_DATA, 32'hA0, 1'b0); settle();
    chk("get_no_bypass", rsp_valid, 0);
    tick();
    chk("get_stream_valid", rsp_valid, 1);
    chk("get_stream_data", rsp_data, 32'hA0);
    chk("get_stream_last", rsp_last, 0);
    for (int i = 1; i < 4; i++) begin
      d_beat(8'd0, D_ACK_DATA, 32'hA0 + i, 1'b0);
      tick();
    end
    d_idle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("get_rsp%0d_valid", i), rsp_valid, 1);
      chk($sformatf("get_rsp%0d_data", i), rsp_data, 32'hA0 + i);
      chk($sformatf("get_rsp%0d_last", i), rsp_last, (i == 3) ? 1 : 0);
      chk($sformatf("get_rsp%0d_err", i), rsp_err, 0);
      tick();
    end
    rsp_ready = 1'b0; settle();
    chk("get_retired", rsp_valid, 0);

    // PutPartialData len=1, source 1, ack after first A beat
    req_drive(3'd2, 3'd0, 32'h2000, 2'd1);
    tick(); req_valid = 1'b0;
    wvalid = 1'b1; wdata = 32'h1111_1111; wbe = 4'h3; settle();
    chk("ppd_a_valid", a_out.a_valid, 1);
    chk("ppd_a_opcode", a_out.a_opcode, A_PUT_PARTIAL);
    chk("ppd_a_source0", a_out.a_source, 1);
    chk("ppd_a_mask0", a_out.a_mask, 4'h3);
    chk("ppd_a_size", a_out.a_size, 3);
    chk("ppd_a_data0", a_out.a_data, 32'h1111_1111);
    chk("ppd_wready", wready, 1);
    chk("ppd_no_rsp0", rsp_valid, 0);
    tick();
    wdata = 32'h2222_2222; wbe = 4'hC;
    d_beat(8'd1, D_ACK, 32'h0, 1'b0); settle();
    chk("ppd_a_mask1", a_out.a_mask, 4'hC);
    chk("ppd_a_source1", a_out.a_source, 1);
    chk("ppd_a_data1", a_out.a_data, 32'h2222_2222);
    chk("ppd_no_rsp1", rsp_valid, 0);
    tick(); wvalid = 1'b0; d_idle(); settle();
    chk("ppd_a_done", a_out.a_valid, 0);
    chk("ppd_rsp_valid", rsp_valid, 1);
    chk("ppd_rsp_data", rsp_data, 0);
    chk("ppd_rsp_last", rsp_last, 1);
    chk("ppd_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; settle();
    chk("ppd_retired", rsp_valid, 0);

    // Four Gets on sources 0-3, responses 3,1,0,2
    rst = 1'b1; tick(); rst = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      req_drive(3'd0, 3'd0, 32'h100 * i, 2'd0); settle();
      chk($sformatf("ooo_ready%0d", i), req_ready, 1);
      tick(); req_valid = 1'b0; settle();
      chk($sformatf("ooo_src%0d", i), a_out.a_source, i);
      tick();
    end
    req_drive(3'd0, 3'd0, 32'h500, 2'd0); settle();
    chk("ooo_full_stall", req_ready, 0);
    d_beat(8'd3, D_ACK_DATA, 32'hD3, 1'b0); tick();
    d_beat(8'd1, D_ACK_DATA, 32'hD1, 1'b0); settle();
    chk("ooo_wait_head_a", rsp_valid, 0);
    tick();
    d_beat(8'd0, D_ACK_DATA, 32'hD0, 1'b0); settle();
    chk("ooo_wait_head_b", rsp_valid, 0);
    chk("ooo_still_full", req_ready, 0);
    tick(); d_idle(); settle();
    chk("ooo_h0_valid", rsp_valid, 1);
    chk("ooo_h0_data", rsp_data, 32'hD0);
    chk("ooo_h0_last", rsp_last, 1);
    rsp_ready = 1'b1; settle();
    chk("ooo_no_ready_bypass", req_ready, 0);
    tick();
    d_beat(8'd2, D_ACK_DATA, 32'hD2, 1'b0); settle();
    chk("ooo_ready_after_retire", req_ready, 1);
    chk("ooo_h1_data", rsp_data, 32'hD1);
    tick(); req_valid = 1'b0; d_idle(); settle();
    chk("ooo_fifth_src", a_out.a_source, 0);
    chk("ooo_fifth_a_valid", a_out.a_valid, 1);
    chk("ooo_h2_valid", rsp_valid, 1);
    chk("ooo_h2_data", rsp_data, 32'hD2);
    tick();
    chk("ooo_h3_valid", rsp_valid, 1);
    chk("ooo_h3_data", rsp_data, 32'hD3);
    tick(); rsp_ready = 1'b0; settle();
    chk("ooo_fifth_pending", rsp_valid, 0);
    chk("ooo_ready_occ1", req_ready, 1);
    d_beat(8'd0, D_ACK_DATA, 32'hE5, 1'b0); tick(); d_idle(); settle();
    chk("ooo_fifth_data", rsp_data, 32'hE5);
    chk("ooo_fifth_last", rsp_last, 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; settle();
    chk("ooo_drained", rsp_valid, 0);

    // ArithmeticData len=1 param 2 on source 1, d_error on second beat
    req_drive(3'd3, 3'd2, 32'h3004, 2'd1);
    tick(); req_valid = 1'b0;
    wvalid = 1'b1; wdata = 32'h5; wbe = 4'hF; settle();
    chk("arith_a_param", a_out.a_param, 2);
    chk("arith_a_opcode", a_out.a_opcode, A_ARITH);
    chk("arith_a_size", a_out.a_size, 3);
    chk("arith_a_address", a_out.a_address, 32'h3000);
    chk("arith_a_source", a_out.a_source, 1);
    tick(); wdata = 32'h6; tick(); wvalid = 1'b0; settle();
    chk("arith_a_done", a_out.a_valid, 0);
    d_beat(8'd1, D_ACK_DATA, 32'h77, 1'b0); tick(); d_idle(); settle();
    chk("arith_b0_data", rsp_data, 32'h77);
    chk("arith_b0_err", rsp_err, 0);
    chk("arith_b0_last", rsp_last, 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    d_beat(8'd1, D_ACK_DATA, 32'h88, 1'b1); tick(); d_idle(); settle();
    chk("arith_b1_valid", rsp_valid, 1);
    chk("arith_b1_data", rsp_data, 32'h88);
    chk("arith_b1_err", rsp_err, 1);
    chk("arith_b1_last", rsp_last, 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; settle();
    chk("arith_retired", rsp_valid, 0);

    // D beat for an unallocated source
    rst = 1'b1; tick(); rst = 1'b0; settle();
    req_drive(3'd0, 3'd0, 32'h40, 2'd0);
    tick(); req_valid = 1'b0; tick();
    d_beat(8'd3, D_ACK_DATA, 32'hBAD, 1'b0); tick(); d_idle(); settle();
    chk("perr_set", proto_err, 1);
    chk("perr_dropped", rsp_valid, 0);
    d_beat(8'd0, D_ACK_DATA, 32'h99, 1'b0); tick(); d_idle(); settle();
    chk("perr_good_data", rsp_data, 32'h99);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; settle();
    chk("perr_sticky", proto_err, 1);

    // Reserved op behaves as Intent with param 0
    rst = 1'b1; tick(); rst = 1'b0; settle();
    chk("rsvd_perr_cleared", proto_err, 0);
    req_drive(3'd7, 3'd5, 32'h80, 2'd0);
    tick(); req_valid = 1'b0; settle();
    chk("rsvd_a_opcode", a_out.a_opcode, A_INTENT);
    chk("rsvd_a_param", a_out.a_param, 0);
    chk("rsvd_a_mask", a_out.a_mask, 4'hF);
    chk("rsvd_wready", wready, 0);
    chk("rsvd_perr", proto_err, 1);
    tick();
    d_beat(8'd0, D_HINT_ACK, 32'h1234, 1'b0); tick(); d_idle(); settle();
    chk("rsvd_rsp_data", rsp_data, 0);
    chk("rsvd_rsp_last", rsp_last, 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Reset in the middle of a 4-beat PutFullData
    rst = 1'b1; tick(); rst = 1'b0; settle();
    req_drive(3'd1, 3'd0, 32'h600, 2'd2);
    tick(); req_valid = 1'b0;
    wvalid = 1'b1; wdata = 32'hC0; wbe = 4'h1; settle();
    chk("pfd_a_mask_full", a_out.a_mask, 4'hF);
    chk("pfd_a_size", a_out.a_size, 4);
    chk("pfd_busy", a_busy, 1);
    tick(); wdata = 32'hC1; rst = 1'b1; settle();
    chk("pfd_beat1_presented", a_out.a_valid, 1);
    tick(); settle();
    chk("pfd_rst_a_valid", a_out.a_valid, 0);
    chk("pfd_rst_rsp_valid", rsp_valid, 0);
    chk("pfd_rst_wready", wready, 0);
    rst = 1'b0; wvalid = 1'b0; tick(); settle();
    chk("pfd_req_ready", req_ready, 1);
    chk("pfd_idle", a_out.a_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
